// File: rtl/sha_acc_host.sv
// sha_acc_host: Avalon-MM initiator that loads a 512-bit block into the SHA-256
// accelerator, starts it, collects the eight result words and hands the 256-bit
// hash on through a valid/ready stream.
module sha_acc_host #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] START_FLAG     = 32'hffffffff,
  parameter logic [31:0] ACK_FLAG       = 32'h0f0f0f0f
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         hash_valid,
  input  logic         hash_ready,
  output logic [255:0] hash_data,
  output logic         busy,
  output logic         timeout,
  output logic         acc_chipselect,
  output logic         acc_write,
  output logic [4:0]   acc_address,
  output logic [31:0]  acc_writedata,
  input  logic [31:0]  acc_data_in,
  input  logic [3:0]   acc_writeaddress
);

  localparam int unsigned BLK_W   = 512;
  localparam int unsigned HASH_W  = 256;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned RIDX_W  = 4;
  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [ADDR_W-1:0]  CMD_ADDR    = ADDR_W'(16);
  localparam logic [CNT_W-1:0]   LAST_WORD   = CNT_W'(15);
  localparam logic [RIDX_W-1:0]  DONE_MARK   = RIDX_W'(8);
  localparam logic [TIMER_W-1:0] TIMER_MAX   = '1;
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_ACK,
    S_ACK_ABORT,
    S_OUT
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BLK_W-1:0]    blk_q, blk_d;
  logic [HASH_W-1:0]   cap_q, cap_d;
  logic [HASH_W-1:0]   hash_q, hash_d;
  logic                armed_q, armed_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [TIMER_W-1:0]  timer_inc;
  logic                timeout_q, timeout_d;
  logic                hash_valid_q, hash_valid_d;
  logic                blk_ready_q, blk_ready_d;
  logic                busy_q, busy_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;

  // Saturating increment so the wait timer never wraps
  assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_W'(1);

  // Next-state and datapath update for the job sequencer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    cap_d     = cap_q;
    hash_d    = hash_q;
    armed_d   = armed_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (blk_valid) begin
          blk_d   = blk_data;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q == LAST_WORD) begin
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_START: begin
        armed_d = 1'b0;
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!acc_writeaddress[3]) begin
          cap_d[{acc_writeaddress[2:0], 5'd0} +: WORD_W] = acc_data_in;
        end
        // A marker seen before any other index is left over from an old job
        if (acc_writeaddress != DONE_MARK) begin
          armed_d = 1'b1;
        end
        timer_d = timer_inc;
        if (armed_q && (acc_writeaddress == DONE_MARK)) begin
          hash_d  = cap_q;
          state_d = S_ACK;
        end else if ((TIMEOUT_CYCLES != 0) && (timer_inc == TIMER_LIMIT)) begin
          timeout_d = 1'b1;
          state_d   = S_ACK_ABORT;
        end
      end
      S_ACK: begin
        state_d = S_OUT;
      end
      S_ACK_ABORT: begin
        state_d = S_IDLE;
      end
      S_OUT: begin
        if (hash_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output lands in a register
  always_comb begin
    wr_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;

    case (state_d)
      S_LOAD: begin
        wr_d    = 1'b1;
        addr_d  = ADDR_W'(cnt_d);
        wdata_d = blk_d[{cnt_d, 5'd0} +: WORD_W];
      end
      S_START: begin
        wr_d    = 1'b1;
        addr_d  = CMD_ADDR;
        wdata_d = START_FLAG;
      end
      S_ACK, S_ACK_ABORT: begin
        wr_d    = 1'b1;
        addr_d  = CMD_ADDR;
        wdata_d = ACK_FLAG;
      end
      default: begin
        wr_d = 1'b0;
      end
    endcase

    blk_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    hash_valid_d = (state_d == S_OUT);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      blk_q        <= '0;
      cap_q        <= '0;
      hash_q       <= '0;
      armed_q      <= 1'b0;
      timer_q      <= '0;
      timeout_q    <= 1'b0;
      hash_valid_q <= 1'b0;
      blk_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      blk_q        <= blk_d;
      cap_q        <= cap_d;
      hash_q       <= hash_d;
      armed_q      <= armed_d;
      timer_q      <= timer_d;
      timeout_q    <= timeout_d;
      hash_valid_q <= hash_valid_d;
      blk_ready_q  <= blk_ready_d;
      busy_q       <= busy_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign blk_ready      = blk_ready_q;
  assign hash_valid     = hash_valid_q;
  assign hash_data      = hash_q;
  assign busy           = busy_q;
  assign timeout        = timeout_q;
  assign acc_chipselect = wr_q;
  assign acc_write      = wr_q;
  assign acc_address    = addr_q;
  assign acc_writedata  = wdata_q;

endmodule

// File: tb/tb_sha_acc_host.sv
// tb_sha_acc_host: directed bench for sha_acc_host with a scripted accelerator.
module tb_sha_acc_host;

  localparam logic [31:0] START_F = 32'hffffffff;
  localparam logic [31:0] ACK_F   = 32'h0f0f0f0f;

  logic         clk = 1'b0;
  logic         reset;

  logic         blk_valid, blk_ready, hash_valid, hash_ready, busy, timeout;
  logic [511:0] blk_data;
  logic [255:0] hash_data;
  logic         acc_chipselect, acc_write;
  logic [4:0]   acc_address;
  logic [31:0]  acc_writedata, acc_data_in;
  logic [3:0]   acc_writeaddress;

  logic         t_blk_valid, t_blk_ready, t_hash_valid, t_hash_ready, t_busy, t_timeout;
  logic [511:0] t_blk_data;
  logic [255:0] t_hash_data;
  logic         t_acc_chipselect, t_acc_write;
  logic [4:0]   t_acc_address;
  logic [31:0]  t_acc_writedata, t_acc_data_in;
  logic [3:0]   t_acc_writeaddress;

  sha_acc_host dut (
    .clk(clk), .reset(reset),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .hash_valid(hash_valid), .hash_ready(hash_ready), .hash_data(hash_data),
    .busy(busy), .timeout(timeout),
    .acc_chipselect(acc_chipselect), .acc_write(acc_write),
    .acc_address(acc_address), .acc_writedata(acc_writedata),
    .acc_data_in(acc_data_in), .acc_writeaddress(acc_writeaddress)
  );

  sha_acc_host #(.TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .reset(reset),
    .blk_valid(t_blk_valid), .blk_ready(t_blk_ready), .blk_data(t_blk_data),
    .hash_valid(t_hash_valid), .hash_ready(t_hash_ready), .hash_data(t_hash_data),
    .busy(t_busy), .timeout(t_timeout),
    .acc_chipselect(t_acc_chipselect), .acc_write(t_acc_write),
    .acc_address(t_acc_address), .acc_writedata(t_acc_writedata),
    .acc_data_in(t_acc_data_in), .acc_writeaddress(t_acc_writeaddress)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int strobe_err = 0;
  int to_main = 0;
  int hs_cyc = 0;
  int t_wr = 0, t_to = 0, t_hv = 0, t_ack_c = -1;
  int          wl_cyc[$];
  logic [4:0]  wl_a[$];
  logic [31:0] wl_d[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write log and protocol watch, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      if (acc_write !== acc_chipselect) strobe_err++;
      if (acc_write !== 1'b1 && (acc_address !== 5'd0 || acc_writedata !== 32'd0)) strobe_err++;
      if (t_acc_write !== t_acc_chipselect) strobe_err++;
      if (acc_write === 1'b1) begin
        wl_cyc.push_back(cyc);
        wl_a.push_back(acc_address);
        wl_d.push_back(acc_writedata);
      end
      if (timeout === 1'b1) to_main++;
      if (t_acc_write === 1'b1) t_wr++;
      if (t_timeout === 1'b1) t_to++;
      if (t_hash_valid === 1'b1) t_hv++;
      if (t_acc_write === 1'b1 && t_acc_address === 5'd16 && t_acc_writedata === ACK_F) t_ack_c = cyc;
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] mk_blk(input logic [31:0] base, input logic [31:0] step);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = base + step * 32'(i);
    return b;
  endfunction

  function automatic logic [255:0] mk_hash(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] h;
    for (int j = 0; j < 8; j++) h[j*32 +: 32] = base + step * 32'(j);
    return h;
  endfunction

  // One full job on the main instance; always entered and left at a falling edge
  task automatic run_job(input string nm, input logic [511:0] blk, input logic [255:0] hsh,
                         input int lat, input bit stale, input int bp,
                         input bit chain, input logic [511:0] nxt, input bit b2b);
    int t, acc_c, st_c, mk_c, ack_c, bad, prev_hs;
    logic [4:0]  ea;
    logic [31:0] ed;
    prev_hs = hs_cyc;
    wl_cyc.delete(); wl_a.delete(); wl_d.delete();
    acc_writeaddress = stale ? 4'h8 : 4'hF;
    acc_data_in = 32'h0;
    blk_valid = 1'b1;
    blk_data  = blk;
    t = 0;
    while (blk_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    check($sformatf("%s:accept", nm), 256'(blk_ready), 256'(1));
    acc_c = cyc;
    @(negedge clk);
    blk_valid = chain;
    blk_data  = chain ? nxt : ~blk;
    t = 0;
    while (!(acc_write === 1'b1 && acc_address === 5'd16) && t < 100) begin @(negedge clk); t++; end
    st_c = cyc;
    check($sformatf("%s:start_cycle", nm), 256'(st_c), 256'(acc_c + 17));
    if (stale) begin
      repeat (3) @(negedge clk);
      acc_writeaddress = 4'hF;
    end
    repeat (lat) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      acc_writeaddress = 4'(j);
      acc_data_in = hsh[j*32 +: 32];
      @(negedge clk);
    end
    acc_writeaddress = 4'h8;
    acc_data_in = 32'h0;
    mk_c = cyc;
    t = 0;
    while (!(acc_write === 1'b1 && acc_address === 5'd16) && t < 100) begin @(negedge clk); t++; end
    ack_c = cyc;
    check($sformatf("%s:ack_cycle", nm), 256'(ack_c), 256'(mk_c + 1));
    @(negedge clk);
    acc_writeaddress = 4'hF;
    t = 0;
    while (hash_valid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    check($sformatf("%s:hash_valid", nm), 256'(hash_valid), 256'(1));
    check($sformatf("%s:hash_data", nm), hash_data, hsh);
    bad = 0;
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      if (hash_valid !== 1'b1 || hash_data !== hsh || blk_ready !== 1'b0) bad++;
    end
    if (bp > 0) check($sformatf("%s:backpressure_hold", nm), 256'(bad), 256'(0));
    hash_ready = 1'b1;
    hs_cyc = cyc;
    @(negedge clk);
    hash_ready = 1'b0;
    check($sformatf("%s:hash_valid_drop", nm), 256'(hash_valid), 256'(0));
    check($sformatf("%s:blk_ready_after", nm), 256'(blk_ready), 256'(1));
    check($sformatf("%s:n_writes", nm), 256'(wl_a.size()), 256'(18));
    for (int i = 0; i < wl_a.size() && i < 18; i++) begin
      ea = (i < 16) ? 5'(i) : 5'd16;
      ed = (i < 16) ? blk[i*32 +: 32] : ((i == 16) ? START_F : ACK_F);
      check($sformatf("%s:wr%0d_addr", nm, i), 256'(wl_a[i]), 256'(ea));
      check($sformatf("%s:wr%0d_data", nm, i), 256'(wl_d[i]), 256'(ed));
    end
    if (wl_cyc.size() > 0) begin
      check($sformatf("%s:first_write_cycle", nm), 256'(wl_cyc[0]), 256'(acc_c + 1));
      if (b2b) check($sformatf("%s:b2b_gap", nm), 256'(wl_cyc[0]), 256'(prev_hs + 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, ts, tc;
    reset = 1'b0;
    blk_valid = 1'b0; blk_data = '0; hash_ready = 1'b0;
    acc_data_in = 32'h0; acc_writeaddress = 4'hF;
    t_blk_valid = 1'b0; t_blk_data = '0; t_hash_ready = 1'b0;
    t_acc_data_in = 32'h0; t_acc_writeaddress = 4'hF;
    repeat (3) @(negedge clk);
    check("rst:acc_write", 256'(acc_write), 256'(0));
    check("rst:busy", 256'(busy), 256'(0));
    check("rst:hash_valid", 256'(hash_valid), 256'(0));
    check("rst:hash_data", hash_data, 256'(0));
    check("rst:timeout", 256'(timeout), 256'(0));
    reset = 1'b1;
    @(negedge clk);
    check("rst:blk_ready", 256'(blk_ready), 256'(1));

    run_job("basic", mk_blk(32'h0000_0100, 32'd1), mk_hash(32'hA5A5_0000, 32'd1),
            64, 1'b0, 0, 1'b0, '0, 1'b0);
    run_job("stale", mk_blk(32'hDEAD_0000, 32'h11), mk_hash(32'h5A5A_0000, 32'd3),
            10, 1'b1, 0, 1'b0, '0, 1'b0);
    run_job("bp", mk_blk(32'h1234_0000, 32'h101), mk_hash(32'hC0DE_0000, 32'h10),
            20, 1'b0, 20, 1'b1, mk_blk(32'hBEEF_0000, 32'h7), 1'b0);
    run_job("b2b", mk_blk(32'hBEEF_0000, 32'h7), mk_hash(32'h0BAD_F000, 32'h5),
            5, 1'b0, 0, 1'b0, '0, 1'b1);

    // Reset in the middle of the load burst
    blk_valid = 1'b1;
    blk_data = mk_blk(32'h7000_0000, 32'd1);
    t = 0;
    while (!(acc_write === 1'b1 && acc_address === 5'd7) && t < 100) begin @(negedge clk); t++; end
    check("rstload:at_addr7", 256'(acc_address), 256'(7));
    #2 reset = 1'b0;
    #1;
    check("rstload:acc_write_async", 256'(acc_write), 256'(0));
    check("rstload:acc_cs_async", 256'(acc_chipselect), 256'(0));
    check("rstload:busy_async", 256'(busy), 256'(0));
    blk_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstload:busy_after", 256'(busy), 256'(0));
    check("rstload:blk_ready_after", 256'(blk_ready), 256'(1));
    run_job("post_rst", mk_blk(32'h2222_0000, 32'h3), mk_hash(32'h3333_0000, 32'h9),
            8, 1'b0, 0, 1'b0, '0, 1'b0);

    // Timeout instance: the accelerator never reports done
    t_wr = 0; t_to = 0; t_hv = 0; t_ack_c = -1;
    t_blk_valid = 1'b1;
    t_blk_data = mk_blk(32'h0000_0100, 32'd1);
    t = 0;
    while (t_blk_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    t_blk_valid = 1'b0;
    t = 0;
    while (!(t_acc_write === 1'b1 && t_acc_address === 5'd16) && t < 100) begin @(negedge clk); t++; end
    ts = cyc;
    check("to:start_data", 256'(t_acc_writedata), 256'(START_F));
    t = 0;
    while (t_timeout !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    tc = cyc;
    check("to:pulse_cycle", 256'(tc), 256'(ts + 17));
    repeat (6) @(negedge clk);
    check("to:pulse_count", 256'(t_to), 256'(1));
    check("to:ack_cycle", 256'(t_ack_c), 256'(ts + 17));
    check("to:write_count", 256'(t_wr), 256'(18));
    check("to:no_hash_valid", 256'(t_hv), 256'(0));
    check("to:blk_ready", 256'(t_blk_ready), 256'(1));
    check("to:busy", 256'(t_busy), 256'(0));

    check("strobe_rules", 256'(strobe_err), 256'(0));
    check("main_no_timeout", 256'(to_main), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha_acc_host.md
Name: sha_acc_host

Overview:
- Avalon-MM initiator that drives the memory-mapped SHA-256 accelerator.
- Accepts a 512-bit block on a valid/ready stream and writes it to the accelerator as 16 words, then writes the start flag.
- Collects the 8 result words from the accelerator's `writeaddress`/`data_out` result port, writes the handshake ack, and presents the 256-bit hash on a valid/ready stream.
- Sits between the mining controller and the accelerator, replacing software-driven loading.

Parameters:
- TIMEOUT_CYCLES, 4096: maximum cycles in WAIT before abort; 0 disables the timeout.
- START_FLAG, 32'hffffffff: writedata for the start command at address 16.
- ACK_FLAG, 32'h0f0f0f0f: writedata for the result acknowledge at address 16.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- blk_valid  in  1  block available
- blk_ready  out  1  block accepted when both valid and ready are high
- blk_data  in  512  message block; word i = blk_data[32i+31:32i]
- hash_valid  out  1  hash result available
- hash_ready  in  1  consumer accepts the hash
- hash_data  out  256  result; word i = hash_data[32i+31:32i]
- busy  out  1  high in every state except IDLE
- timeout  out  1  one-cycle pulse when a job aborts
- acc_chipselect  out  1  accelerator chipselect
- acc_write  out  1  accelerator write strobe
- acc_address  out  5  accelerator word address
- acc_writedata  out  32  accelerator write data
- acc_data_in  in  32  accelerator result word
- acc_writeaddress  in  4  accelerator result index: 0-7 = word index, 4'b1000 = done marker

Behaviour:
- **Reset.** Asserting reset forces, asynchronously, all of the following to 0, including mid-write: acc_* outputs, hash_valid, hash_data, busy, timeout, the capture registers, the counters, and the armed flag. State becomes IDLE.
- **Registered outputs.** All outputs are registered.
- **Write strobes.** acc_write and acc_chipselect are always asserted together. One write per cycle, no wait states. Outside write cycles, acc_address and acc_writedata are 0.
- **IDLE.**
  - blk_ready = 1.
  - On blk_valid, latch blk_data, clear the word counter, and go to LOAD.
- **LOAD.**
  - 16 consecutive write cycles: acc_address = i, acc_writedata = word i, for i = 0..15 ascending.
  - After i = 15, go to START.
- **START.**
  - One write: acc_address = 16, acc_writedata = START_FLAG.
  - Clear the armed flag and the timer, then go to WAIT.
- **Cycle count.** First accelerator write occurs 1 cycle after block acceptance; start write occurs 17 cycles after acceptance.
- **WAIT (no writes).**
  - Capture: whenever acc_writeaddress[3] = 0, word[acc_writeaddress[2:0]] <= acc_data_in. Last value per index wins.
  - Arming: armed <= 1 on any cycle with acc_writeaddress != 4'b1000.
  - A done marker present before arming is stale (left over from a previous unacknowledged job) and is ignored.
  - Done: armed && acc_writeaddress == 4'b1000 -> load hash_data from the capture registers, go to ACK.
  - Timer increments each WAIT cycle. If TIMEOUT_CYCLES != 0 and the timer reaches TIMEOUT_CYCLES before done: pulse timeout for 1 cycle, go to ACK_ABORT.
- **ACK.** One write: acc_address = 16, acc_writedata = ACK_FLAG. Then go to OUT.
- **ACK_ABORT.** Same write as ACK (clears any pending accelerator marker). Then go to IDLE; no hash is produced.
- **OUT.**
  - hash_valid = 1; hash_data is held stable until hash_ready.
  - On hash_ready, clear hash_valid and go to IDLE.
  - blk_ready stays 0 until the cycle after the hash handshake, so a new block is never accepted in the same cycle.
- **Input ordering.** blk_valid is ignored outside IDLE; blk_data is not re-sampled mid-job.
- **Timer width.** The timer saturates and never wraps. Its width is clog2(TIMEOUT_CYCLES + 1), minimum 1.

Test Plan:
1. **Basic job.**
   - Stimulus: block with word i = 32'h0000_0100 + i. Accelerator model returns hash word j = 32'hA5A5_0000 + j after 64 cycles.
   - Required: exactly 16 writes to addresses 0..15 with the matching data, then address 16 = 32'hffffffff. Later one ack write at address 16 = 32'h0f0f0f0f. Then hash_valid with hash_data word j = 32'hA5A5_0000 + j.
2. **Stale marker.**
   - Stimulus: model holds acc_writeaddress = 4'b1000 from the previous job at start time, drops it after 3 cycles, then runs normally.
   - Required: no premature done; hash equals the new result.
3. **Output backpressure.**
   - Stimulus: hash_ready low for 20 cycles, with blk_valid high throughout.
   - Required: hash_valid and hash_data stable, blk_ready = 0. blk_ready = 1 the cycle after the handshake.
4. **Timeout.**
   - Stimulus: TIMEOUT_CYCLES = 16; model never signals done.
   - Required: timeout pulses exactly 1 cycle, 16 cycles into WAIT. One ack write follows. hash_valid never rises. Returns to IDLE with blk_ready = 1.
5. **Reset mid-LOAD.**
   - Stimulus: assert reset during the write to address 7.
   - Required: acc_write and acc_chipselect drop immediately (async). After release, busy = 0 and blk_ready = 1; the next job writes from address 0.
6. **Back-to-back jobs.**
   - Stimulus: two different blocks queued.
   - Required: two complete write/ack sequences and two distinct, correct hashes in order; the second job's first write occurs 2 cycles after the first hash handshake.
